// File: rtl/mips_muldiv_unit_pkg.sv
// mips_pkg: shared definitions for the chocorrol multiply/divide unit.
//   - OP_* : opIn encodings for MULT, MULTU, DIV, DIVU
//   - stateT : sequencer states IDLE -> RUN -> FIXUP -> DONE
//   - DEFAULT_WIDTH : operand and HI/LO width
//   - isSignedOp / isDivOp : opcode decode helpers
package mips_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } stateT;

   // MULT and DIV are the signed forms (opcode bit 0 clear).
   function automatic logic isSignedOp(input logic [1:0] op);
      return ~op[0];
   endfunction

   // DIV and DIVU have opcode bit 1 set.
   function automatic logic isDivOp(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   isDivIn   : 0 = shift-add multiply step, 1 = restoring divide step
//   accIn     : 2*WIDTH accumulator
//               multiply: {partial product high half, remaining multiplier bits}
//               divide  : {partial remainder, remaining dividend / quotient bits}
//   operandIn : multiplicand (multiply) or divisor (divide)
//   accOut    : accumulator after this iteration
module muldiv_step
   import mips_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 isDivIn,
   input  logic [2*WIDTH-1:0]   accIn,
   input  logic [WIDTH-1:0]     operandIn,
   output logic [2*WIDTH-1:0]   accOut
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      // Multiply: add the multiplicand when the current multiplier LSB is set;
      // the carry becomes the new top bit as the accumulator shifts right.
      sum     = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operandIn} : '0);
      // Divide: shift the next dividend bit into the remainder. The remainder
      // is below the divisor before the shift, so WIDTH+1 bits always suffice.
      shifted = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
      fits    = (shifted >= {1'b0, operandIn});
      // When the divisor fits, the difference is below the divisor, so the
      // low WIDTH bits of the subtraction are exact.
      diff    = shifted[WIDTH-1:0] - operandIn;
      accOut  = {sum, accIn[WIDTH-1:1]};
      if (isDivIn) begin
         if (fits) begin
            accOut = {diff, accIn[WIDTH-2:0], 1'b1};
         end else begin
            accOut = {shifted[WIDTH-1:0], accIn[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clkIn    : core clock, rising edge
//   rstIn    : synchronous active-high reset, aborts any operation
//   startIn  : one-cycle request, honoured only in IDLE
//   opIn     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   aIn/bIn  : rs/rt operands, sampled only with startIn
//   hiWeIn/loWeIn/wrDataIn : MTHI/MTLO writes, honoured when not busy
//   busyOut  : high during RUN and FIXUP
//   doneOut  : one-cycle pulse when HI/LO take a new result
//   hiOut/loOut : HI and LO registers
// Operands are reduced to magnitudes at start, WIDTH iterations run on the
// magnitudes, and one FIXUP cycle restores the signs. Latency is fixed.
module mips_muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clkIn,
   input  logic             rstIn,
   input  logic             startIn,
   input  logic [1:0]       opIn,
   input  logic [WIDTH-1:0] aIn,
   input  logic [WIDTH-1:0] bIn,
   input  logic             hiWeIn,
   input  logic             loWeIn,
   input  logic [WIDTH-1:0] wrDataIn,
   output logic             busyOut,
   output logic             doneOut,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   stateT              stateReg;
   stateT              stateNext;
   logic [CNT_W-1:0]   cntReg;
   logic [2*WIDTH-1:0] accReg;
   logic [2*WIDTH-1:0] accStep;
   logic [2*WIDTH-1:0] accFixed;
   logic [WIDTH-1:0]   operandReg;
   logic               isDivReg;
   logic               negProdReg;
   logic               negQuotReg;
   logic               negRemReg;

   logic               startSigned;
   logic               startDiv;
   logic               aNeg;
   logic               bNeg;
   logic               bZero;
   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;

   // ---------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         stateReg <= S_IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         S_IDLE:  if (startIn) stateNext = S_RUN;
         S_RUN:   if (cntReg == LAST_CNT) stateNext = S_FIXUP;
         S_FIXUP: stateNext = S_DONE;
         S_DONE:  stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   assign busyOut = (stateReg == S_RUN) || (stateReg == S_FIXUP);

   // ---------------------------------------------------------------
   // Operand conditioning at start
   // ---------------------------------------------------------------
   always_comb begin
      startSigned = isSignedOp(opIn);
      startDiv    = isDivOp(opIn);
      aNeg        = startSigned & aIn[WIDTH-1];
      bNeg        = startSigned & bIn[WIDTH-1];
      bZero       = (bIn == '0);
      // The most negative value maps onto itself, which is already its
      // correct unsigned magnitude.
      aMag        = aNeg ? -aIn : aIn;
      bMag        = bNeg ? -bIn : bIn;
   end

   // ---------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------
   muldiv_step #(
      .WIDTH(WIDTH)
   ) stepInst (
      .isDivIn  (isDivReg),
      .accIn    (accReg),
      .operandIn(operandReg),
      .accOut   (accStep)
   );

   always_comb begin
      accFixed = accReg;
      if (isDivReg) begin
         if (negQuotReg) accFixed[WIDTH-1:0]       = -accReg[WIDTH-1:0];
         if (negRemReg)  accFixed[2*WIDTH-1:WIDTH] = -accReg[2*WIDTH-1:WIDTH];
      end else if (negProdReg) begin
         accFixed = -accReg;
      end
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         cntReg     <= '0;
         accReg     <= '0;
         operandReg <= '0;
         isDivReg   <= 1'b0;
         negProdReg <= 1'b0;
         negQuotReg <= 1'b0;
         negRemReg  <= 1'b0;
      end else begin
         case (stateReg)
            S_IDLE: begin
               if (startIn) begin
                  cntReg     <= '0;
                  isDivReg   <= startDiv;
                  // Divide keeps the dividend in the low half and shifts it
                  // into the remainder; multiply keeps the multiplier there
                  // and consumes it LSB first.
                  accReg     <= {{WIDTH{1'b0}}, (startDiv ? aMag : bMag)};
                  operandReg <= startDiv ? bMag : aMag;
                  negProdReg <= aNeg ^ bNeg;
                  // Divide by zero leaves the all-ones quotient untouched;
                  // the remainder sign restore returns the original dividend.
                  negQuotReg <= (aNeg ^ bNeg) & ~bZero;
                  negRemReg  <= aNeg;
               end
            end
            S_RUN: begin
               accReg <= accStep;
               cntReg <= cntReg + CNT_W'(1);
            end
            S_FIXUP: begin
               accReg <= accFixed;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // HI/LO and completion pulse
   // ---------------------------------------------------------------
   // Results land on the edge that leaves DONE. MT writes are applied after
   // the result load so that an MT write issued during DONE takes priority.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         hiOut   <= '0;
         loOut   <= '0;
         doneOut <= 1'b0;
      end else begin
         doneOut <= (stateReg == S_DONE);
         if (stateReg == S_DONE) begin
            hiOut <= accReg[2*WIDTH-1:WIDTH];
            loOut <= accReg[WIDTH-1:0];
         end
         if (hiWeIn && !busyOut) hiOut <= wrDataIn;
         if (loWeIn && !busyOut) loOut <= wrDataIn;
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: the driver pushes the expected
// HI/LO and completion edge for each operation; a monitor pops and compares
// whenever doneOut is seen.
module tb_mips_muldiv_unit;
   import mips_pkg::*;

   localparam int W = 32;

   logic          clkIn = 1'b0;
   logic          rstIn;
   logic          startIn;
   logic [1:0]    opIn;
   logic [W-1:0]  aIn;
   logic [W-1:0]  bIn;
   logic          hiWeIn;
   logic          loWeIn;
   logic [W-1:0]  wrDataIn;
   logic          busyOut;
   logic          doneOut;
   logic [W-1:0]  hiOut;
   logic [W-1:0]  loOut;

   int vectors     = 0;
   int miscompares = 0;
   int edgeCnt     = 0;
   logic [W-1:0] lastHi = '0;
   logic [W-1:0] lastLo = '0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           doneEdge;
      string        tag;
   } expT;

   expT scoreQ[$];

   mips_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clkIn   (clkIn),
      .rstIn   (rstIn),
      .startIn (startIn),
      .opIn    (opIn),
      .aIn     (aIn),
      .bIn     (bIn),
      .hiWeIn  (hiWeIn),
      .loWeIn  (loWeIn),
      .wrDataIn(wrDataIn),
      .busyOut (busyOut),
      .doneOut (doneOut),
      .hiOut   (hiOut),
      .loOut   (loOut)
   );

   always #5 clkIn = ~clkIn;

   always @(posedge clkIn) edgeCnt <= edgeCnt + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference behaviour from the instruction definitions, on wide integers.
   function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sbv;
      sa  = a;
      sbv = b;
      hi  = '0;
      lo  = '0;
      case (op)
         OP_MULT: begin
            sp = longint'(sa) * longint'(sbv);
            hi = sp[63:32];
            lo = sp[31:0];
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         OP_DIV: begin
            if (b == '0) begin
               lo = '1;
               hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = '0;
            end else begin
               lo = 32'(sa / sbv);
               hi = 32'(sa % sbv);
            end
         end
         default: begin
            if (b == '0) begin
               lo = '1;
               hi = a;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every doneOut pulse must match the oldest outstanding operation.
   always @(negedge clkIn) begin : monitorBlk
      expT e;
      if (doneOut === 1'b1) begin
         if (scoreQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: doneOut=1 with nothing outstanding, edge %0d hi=%h lo=%h",
                     edgeCnt, hiOut, loOut);
         end else begin
            e = scoreQ.pop_front();
            check({e.tag, "_hi"}, hiOut, e.hi);
            check({e.tag, "_lo"}, loOut, e.lo);
            check({e.tag, "_latency"}, edgeCnt, e.doneEdge);
            $display("done %s hi=%h lo=%h at edge %0d", e.tag, hiOut, loOut, edgeCnt);
         end
      end
   end

   // mode 0: plain; 1: second start + MTHI/MTLO mid-run; 2: MTLO during DONE;
   // 3: MTHI together with start in IDLE.
   task automatic runOp(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int mode);
      logic [W-1:0] eh;
      logic [W-1:0] el;
      logic [W-1:0] mtVal;
      int           busyCnt;
      expT          e;
      refModel(op, a, b, eh, el);
      mtVal = $urandom;
      if (mode == 2) el = mtVal;
      @(negedge clkIn);
      opIn    = op;
      aIn     = a;
      bIn     = b;
      startIn = 1'b1;
      if (mode == 3) begin
         hiWeIn   = 1'b1;
         wrDataIn = mtVal;
      end
      e.hi       = eh;
      e.lo       = el;
      e.doneEdge = edgeCnt + 1 + W + 2;
      e.tag      = $sformatf("op%0d_%h_%h_m%0d", op, a, b, mode);
      scoreQ.push_back(e);
      busyCnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clkIn);
         startIn = 1'b0;
         hiWeIn  = 1'b0;
         loWeIn  = 1'b0;
         if (k == 1 && mode == 3) check("start_with_mthi", hiOut, mtVal);
         if (busyOut === 1'b1) busyCnt++;
         // Operand inputs wander after start; the result must not follow.
         aIn  = $urandom;
         bIn  = $urandom;
         opIn = 2'($urandom);
         if (k == 5 && mode == 1) begin
            startIn  = 1'b1;
            hiWeIn   = 1'b1;
            loWeIn   = 1'b1;
            wrDataIn = mtVal;
         end
         if (k == 34 && mode == 2) begin
            loWeIn   = 1'b1;
            wrDataIn = mtVal;
         end
      end
      check("busy_cycles", busyCnt, 33);
      if (scoreQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: %0d results outstanding after 40 cycles, required 0", scoreQ.size());
         scoreQ.delete();
      end
      lastHi = eh;
      lastLo = el;
   endtask

   task automatic mtloIdle(input logic [W-1:0] val);
      @(negedge clkIn);
      loWeIn   = 1'b1;
      wrDataIn = val;
      @(negedge clkIn);
      loWeIn = 1'b0;
      check("mtlo_idle_lo", loOut, val);
      check("mtlo_idle_hi", hiOut, lastHi);
      lastLo = val;
   endtask

   task automatic resetAbort();
      @(negedge clkIn);
      opIn    = OP_DIVU;
      aIn     = $urandom;
      bIn     = $urandom | 32'h1;
      startIn = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clkIn);
         startIn = 1'b0;
      end
      rstIn = 1'b1;
      @(negedge clkIn);
      rstIn = 1'b0;
      check("abort_busy", 32'(busyOut), 32'h0);
      check("abort_done", 32'(doneOut), 32'h0);
      check("abort_hi", hiOut, 32'h0);
      check("abort_lo", loOut, 32'h0);
      // Any completion pulse now is unexpected and the monitor reports it.
      repeat (40) @(negedge clkIn);
      lastHi = '0;
      lastLo = '0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", scoreQ.size());
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      rstIn    = 1'b1;
      startIn  = 1'b0;
      opIn     = 2'b00;
      aIn      = '0;
      bIn      = '0;
      hiWeIn   = 1'b0;
      loWeIn   = 1'b0;
      wrDataIn = '0;
      repeat (2) @(negedge clkIn);
      check("reset_hi", hiOut, 32'h0);
      check("reset_lo", loOut, 32'h0);
      check("reset_busy", 32'(busyOut), 32'h0);
      check("reset_done", 32'(doneOut), 32'h0);
      rstIn = 1'b0;

      runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      runOp(OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 0);
      runOp(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
      runOp(OP_DIVU,  32'd100,       32'h0,         0);
      runOp(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
      runOp(OP_DIV,   32'hFFFF_FFFB, 32'h0,         0);
      runOp(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1);
      runOp(OP_DIVU,  32'hDEAD_BEEF, 32'h0000_1234, 2);
      runOp(OP_MULTU, 32'h0001_0001, 32'h0002_0003, 3);
      mtloIdle(32'h0000_1234);
      resetAbort();
      runOp(OP_MULTU, 32'd6, 32'd7, 0);

      for (int i = 0; i < 30; i++) begin
         runOp(2'($urandom), pick(), pick(), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
